tail_light_sequencer: RTL and testbench
=======================================

Name: tail_light_sequencer

Overview:
- Single-clock controller that sequences the six PWM tail-lamp channels for turn, hazard and brake requests.
- Owns the duty-cycle registers consumed by the per-lamp PWM instances, and ramps lamps inner-to-outer in quarter-brightness steps paced by an external step strobe.
- Arbitrates between turn/hazard sequencing and steady brake illumination.
- Sits between the debounced switch inputs and the PWM bank.

Parameters:
- DUTY_W, 8, width of each lamp duty value.
- GAP_STEPS, 4, number of step ticks all sequenced lamps stay dark between sequences (≥1).
- BRAKE_DUTY, 8'h80, duty applied to non-sequenced lamps while brake is asserted (DUTY_W bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- step_tick  in  1  one-cycle strobe; advances the sequence.
- left  in  1  left turn request (level).
- right  in  1  right turn request (level).
- hazard  in  1  hazard request (level).
- brake  in  1  brake request (level).
- duty  out  6*DUTY_W  lamp i duty at [i*DUTY_W +: DUTY_W]. Lamps 0..2 are the right side, 3..5 the left side; 0 and 3 are inner, 2 and 5 are outer.
- busy  out  1  high when state != IDLE.
- active_side  out  2  {left_seq, right_seq} latched for the current sequence.

Behaviour:
- Reset (async, reset=0): state=IDLE, step=0, gap count=0, active_side=2'b00, all duty=0, busy=0. Reset asserted mid-sequence aborts it immediately.
- All outputs are registered. Inputs are sampled on the clk rising edge. Level values are updated one cycle after a change.
- Ramp levels for step k (0..11) on a side:
  - lamp index = k/4 (inner, middle, outer); phase = k%4.
  - Duty = (phase+1) << (DUTY_W-2) for phase 0..2, i.e. 64, 128, 192.
  - Duty = 2^DUTY_W − 1 for phase 3, i.e. 255.
  - Lamps already ramped hold full scale; lamps not yet reached are 0.
- States:
  - IDLE:
    - On step_tick, evaluate requests.
    - hazard=1 → active_side=11.
    - else left^right=1 → active_side={left,right}.
    - else stay IDLE.
    - Both left and right without hazard is treated as no request.
    - On a valid request, go to RAMP with step=0.
  - RAMP:
    - Each step_tick increments step.
    - On step_tick at step=11, go to GAP with count=0.
    - Request changes during RAMP are ignored; the sequence always runs to completion.
  - GAP:
    - Sequenced lamps are dark.
    - Each step_tick increments count.
    - On step_tick at count=GAP_STEPS−1, go to IDLE and clear active_side.
- Without step_tick the state holds; step_tick is ignored during reset.
- Duty source per lamp, evaluated every cycle (not gated by step_tick):
  - Sequenced side in RAMP: ramp level.
  - Sequenced side in GAP: 0.
  - Any other lamp: BRAKE_DUTY if brake=1, else 0.
  - Brake never overrides a sequenced lamp.
- Period with the request held continuously: 13+GAP_STEPS step_ticks from one step=0 entry to the next (17 with defaults).
- Widths: step is a 4-bit counter; gap count is sized by $clog2(GAP_STEPS)+1. Neither counter wraps, because exits are explicit.

Test Plan:
- Reset: reset=0 mid-RAMP (step 6) → next cycle all duty=0, busy=0, active_side=00. After release, state is IDLE and the next tick with left=1 starts at step 0.
- Left turn: left=1, tick → lamp3=64. Three more ticks → lamp3=255. Ticks 5–8 → lamp4 goes 64/128/192/255. Tick 12 → lamp5=255. Lamps 0–2 stay 0 throughout.
- Gap and repeat: right held → after step 11, the next tick gives lamps 0–2=0 and busy=1. After 4 more ticks busy=0. The next tick gives lamp0=64 (17 ticks after the previous lamp0=64).
- Hazard vs turn: hazard=1, left=1, right=1 → active_side=11 and both sides ramp identically. left=1, right=1, hazard=0 → stays IDLE, all duty 0.
- Brake overlay: brake=1 in IDLE → all six duty=8'h80 one cycle later. During a left sequence, lamps 0–2=8'h80 and lamps 3–5 follow the ramp. Brake drops → lamps 0–2=0 next cycle.
- Request withdrawal: left=1 starts a sequence; deassert left at step 2 → the sequence completes through step 11 and GAP, then stays IDLE.

Source files
------------

// File: rtl/tail_light_sequencer_if.sv
// Switch-side requests and PWM-bank duty outputs of the tail-light sequencer.
interface tail_light_sequencer_if #(
  parameter int unsigned DUTY_W = 8
);
  logic                  step_tick;
  logic                  left;
  logic                  right;
  logic                  hazard;
  logic                  brake;
  logic [6*DUTY_W-1:0]   duty;
  logic                  busy;
  logic [1:0]            active_side;

  // Request source: drives strobes/levels, observes lamp duties.
  modport master (
    output step_tick, left, right, hazard, brake,
    input  duty, busy, active_side
  );

  // Sequencer: consumes requests, owns the duty registers.
  modport slave (
    input  step_tick, left, right, hazard, brake,
    output duty, busy, active_side
  );
endinterface

// File: rtl/tail_light_sequencer.sv
// Sequences six PWM tail lamps (0..2 right, 3..5 left; inner to outer) for turn/hazard
// requests, ramping in quarter-brightness steps on each step_tick, with a brake overlay
// on lamps that are not part of the running sequence.
module tail_light_sequencer #(
  parameter int unsigned       DUTY_W     = 8,
  parameter int unsigned       GAP_STEPS  = 4,
  parameter logic [DUTY_W-1:0] BRAKE_DUTY = 8'h80
) (
  input  logic                   clk,
  input  logic                   reset,
  tail_light_sequencer_if.slave  bus
);

  localparam int unsigned GapW         = $clog2(GAP_STEPS) + 1;
  localparam int unsigned LampsPerSide = 3;
  localparam int unsigned NumLamps     = 2 * LampsPerSide;
  localparam logic [3:0]  LastStep     = 4'd11;
  localparam logic [GapW-1:0] LastGap  = GapW'(GAP_STEPS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StGap
  } state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 step_q, step_d;
  logic [GapW-1:0]            gap_q, gap_d;
  logic [1:0]                 side_q, side_d;
  logic [NumLamps*DUTY_W-1:0] duty_q, duty_d;
  logic                       busy_q, busy_d;

  // Duty of lamp 'lamp' (0 inner .. 2 outer) on a sequenced side at ramp step k.
  function automatic logic [DUTY_W-1:0] ramp_level(input logic [3:0] k,
                                                   input int unsigned lamp);
    int unsigned idx;
    int unsigned phase;
    logic [DUTY_W-1:0] lvl;
    idx   = {28'd0, k} >> 2;
    phase = {28'd0, k} & 32'd3;
    if (lamp < idx) begin
      lvl = '1;
    end else if (lamp == idx) begin
      if (phase == 32'd3) begin
        lvl = '1;
      end else begin
        lvl = DUTY_W'((phase + 32'd1) << (DUTY_W - 2));
      end
    end else begin
      lvl = '0;
    end
    return lvl;
  endfunction

  // Sequence control: request arbitration in IDLE, ramp/gap counting on step ticks.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gap_d   = gap_q;
    side_d  = side_q;
    unique case (state_q)
      StIdle: begin
        if (bus.step_tick) begin
          if (bus.hazard) begin
            side_d  = 2'b11;
            step_d  = 4'd0;
            state_d = StRamp;
          end else if (bus.left ^ bus.right) begin
            // Both turn levels together without hazard is not a request.
            side_d  = {bus.left, bus.right};
            step_d  = 4'd0;
            state_d = StRamp;
          end
        end
      end
      StRamp: begin
        // Requests are not sampled here; a started sequence always completes.
        if (bus.step_tick) begin
          if (step_q == LastStep) begin
            gap_d   = '0;
            step_d  = 4'd0;
            state_d = StGap;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      StGap: begin
        if (bus.step_tick) begin
          if (gap_q == LastGap) begin
            gap_d   = '0;
            side_d  = 2'b00;
            state_d = StIdle;
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        step_d  = 4'd0;
        gap_d   = '0;
        side_d  = 2'b00;
      end
    endcase
  end

  // Lamp duties from the next sequence state so lamps change on the same edge as the state.
  always_comb begin
    duty_d = '0;
    busy_d = (state_d != StIdle);
    for (int i = 0; i < NumLamps; i++) begin
      if (side_d[i / LampsPerSide] && (state_d == StRamp)) begin
        duty_d[i*DUTY_W +: DUTY_W] = ramp_level(step_d, i % LampsPerSide);
      end else if (side_d[i / LampsPerSide] && (state_d == StGap)) begin
        duty_d[i*DUTY_W +: DUTY_W] = '0;
      end else if (bus.brake) begin
        duty_d[i*DUTY_W +: DUTY_W] = BRAKE_DUTY;
      end else begin
        duty_d[i*DUTY_W +: DUTY_W] = '0;
      end
    end
  end

  // State and registered outputs; reset aborts any sequence immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      step_q  <= 4'd0;
      gap_q   <= '0;
      side_q  <= 2'b00;
      duty_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      side_q  <= side_d;
      duty_q  <= duty_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.duty        = duty_q;
  assign bus.busy        = busy_q;
  assign bus.active_side = side_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer: directed scenarios plus a randomized run against a
// position-counting reference model.
module tb_tail_light_sequencer;

  localparam int GAP = 4;
  localparam int PERIOD = 13 + GAP;

  logic clk = 1'b0;
  logic reset = 1'b0;

  tail_light_sequencer_if #(.DUTY_W(8)) bus ();

  tail_light_sequencer #(
    .DUTY_W    (8),
    .GAP_STEPS (GAP),
    .BRAKE_DUTY(8'h80)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: m_pos = ticks since sequence start (0..11 ramp, 12.. gap), -1 when idle.
  int         m_pos   = -1;
  logic [1:0] m_side  = 2'b00;
  logic       m_brake = 1'b0;

  function automatic logic [47:0] model_duty();
    logic [47:0] v;
    int q;
    v = '0;
    for (int i = 0; i < 6; i++) begin
      if (m_pos >= 0 && m_side[i / 3]) begin
        if (m_pos < 12) begin
          // Quarters of brightness lit so far, spread inner to outer.
          q = m_pos + 1 - 4 * (i % 3);
          if (q < 0) q = 0;
          if (q > 4) q = 4;
          v[i*8 +: 8] = (q == 4) ? 8'hFF : 8'(q * 64);
        end
      end else if (m_brake) begin
        v[i*8 +: 8] = 8'h80;
      end
    end
    return v;
  endfunction

  function automatic logic [7:0] lamp(input int i);
    return bus.duty[i*8 +: 8];
  endfunction

  task automatic model_reset();
    m_pos = -1;
    m_side = 2'b00;
    m_brake = 1'b0;
  endtask

  // One clock with the given inputs; model updated at the sampling edge, then #1 settle.
  task automatic step_cycle(input logic t, input logic l, input logic r, input logic h,
                            input logic b);
    @(negedge clk);
    bus.step_tick = t;
    bus.left      = l;
    bus.right     = r;
    bus.hazard    = h;
    bus.brake     = b;
    @(posedge clk);
    m_brake = b;
    if (t) begin
      if (m_pos < 0) begin
        if (h) begin
          m_side = 2'b11;
          m_pos  = 0;
        end else if (l ^ r) begin
          m_side = {l, r};
          m_pos  = 0;
        end
      end else begin
        m_pos++;
        if (m_pos == 12 + GAP) begin
          m_pos  = -1;
          m_side = 2'b00;
        end
      end
    end
    #1;
  endtask

  task automatic flush();
    int n;
    n = 0;
    while (m_pos >= 0 && n < 40) begin
      step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.step_tick = 1'b0;
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.hazard = 1'b0;
    bus.brake = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.duty !== 48'd0 || bus.busy !== 1'b0 || bus.active_side !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: duty=%h busy=%b side=%b, want 0/0/00",
               bus.duty, bus.busy, bus.active_side);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (lamp(4) !== 8'd192) begin
      errors++;
      $display("FAIL reset_pre_step6: lamp4=%0d, want 192", lamp(4));
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.duty !== 48'd0 || bus.busy !== 1'b0 || bus.active_side !== 2'b00) begin
      errors++;
      $display("FAIL reset_abort: duty=%h busy=%b side=%b, want 0/0/00",
               bus.duty, bus.busy, bus.active_side);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.duty !== 48'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: duty=%h busy=%b, want 0/0", bus.duty, bus.busy);
    end
    @(negedge clk);
    reset = 1'b1;
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (lamp(3) !== 8'd64 || bus.busy !== 1'b1 || bus.active_side !== 2'b10) begin
      errors++;
      $display("FAIL reset_restart: lamp3=%0d busy=%b side=%b, want 64/1/10",
               lamp(3), bus.busy, bus.active_side);
    end
    flush();
  endtask

  task automatic test_left_turn();
    int exp4[4];
    exp4 = '{64, 128, 192, 255};
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (lamp(3) !== 8'd64 || bus.duty[23:0] !== 24'd0) begin
      errors++;
      $display("FAIL left_first: lamp3=%0d right=%h, want 64/0", lamp(3), bus.duty[23:0]);
    end
    for (int t = 2; t <= 12; t++) begin
      step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.duty !== model_duty()) begin
        errors++;
        $display("FAIL left_tick%0d: duty=%h, want %h", t, bus.duty, model_duty());
      end
      if (t == 4) begin
        checks++;
        if (lamp(3) !== 8'd255) begin
          errors++;
          $display("FAIL left_lamp3_full: lamp3=%0d, want 255", lamp(3));
        end
      end
      if (t >= 5 && t <= 8) begin
        checks++;
        if (lamp(4) !== 8'(exp4[t-5])) begin
          errors++;
          $display("FAIL left_lamp4_t%0d: lamp4=%0d, want %0d", t, lamp(4), exp4[t-5]);
        end
      end
      if (t == 12) begin
        checks++;
        if (lamp(5) !== 8'd255 || bus.duty[23:0] !== 24'd0) begin
          errors++;
          $display("FAIL left_lamp5_full: lamp5=%0d right=%h, want 255/0",
                   lamp(5), bus.duty[23:0]);
        end
      end
    end
    flush();
  endtask

  task automatic test_gap_repeat();
    int found;
    found = -1;
    step_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (lamp(0) !== 8'd64) begin
      errors++;
      $display("FAIL gap_first: lamp0=%0d, want 64", lamp(0));
    end
    for (int n = 2; n <= 40 && found < 0; n++) begin
      step_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (n == 13) begin
        checks++;
        if (bus.duty[23:0] !== 24'd0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL gap_enter: right=%h busy=%b, want 0/1", bus.duty[23:0], bus.busy);
        end
      end
      if (n == 17) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL gap_exit: busy=%b, want 0", bus.busy);
        end
      end
      if (lamp(0) === 8'd64) found = n;
    end
    checks++;
    if (found - 1 != PERIOD) begin
      errors++;
      $display("FAIL gap_period: restart after %0d ticks (-2 = never), want %0d",
               found - 1, PERIOD);
    end
    flush();
  endtask

  task automatic test_hazard_vs_turn();
    step_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.active_side !== 2'b11) begin
      errors++;
      $display("FAIL hazard_side: side=%b, want 11", bus.active_side);
    end
    for (int t = 2; t <= 12; t++) begin
      step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.duty[23:0] !== bus.duty[47:24] || bus.duty !== model_duty()) begin
        errors++;
        $display("FAIL hazard_tick%0d: duty=%h, want %h", t, bus.duty, model_duty());
      end
    end
    flush();
    repeat (3) begin
      step_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.busy !== 1'b0 || bus.duty !== 48'd0) begin
        errors++;
        $display("FAIL both_turn_idle: busy=%b duty=%h, want 0/0", bus.busy, bus.duty);
      end
    end
  endtask

  task automatic test_brake_overlay();
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.duty !== {6{8'h80}}) begin
      errors++;
      $display("FAIL brake_idle: duty=%h, want %h", bus.duty, {6{8'h80}});
    end
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.duty[23:0] !== {3{8'h80}} || lamp(3) !== 8'd64) begin
      errors++;
      $display("FAIL brake_left: right=%h lamp3=%0d, want 808080/64",
               bus.duty[23:0], lamp(3));
    end
    repeat (5) begin
      step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.duty !== model_duty()) begin
        errors++;
        $display("FAIL brake_ramp: duty=%h, want %h", bus.duty, model_duty());
      end
    end
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.duty[23:0] !== 24'd0 || bus.duty !== model_duty()) begin
      errors++;
      $display("FAIL brake_drop: duty=%h, want %h", bus.duty, model_duty());
    end
    flush();
  endtask

  task automatic test_withdrawal();
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 4; t <= 20; t++) begin
      step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.busy !== (t <= 16) || bus.duty !== model_duty()) begin
        errors++;
        $display("FAIL withdraw_t%0d: busy=%b duty=%h, want %b/%h",
                 t, bus.busy, bus.duty, (t <= 16), model_duty());
      end
      if (t == 12) begin
        checks++;
        if (lamp(5) !== 8'd255) begin
          errors++;
          $display("FAIL withdraw_complete: lamp5=%0d, want 255", lamp(5));
        end
      end
    end
  endtask

  task automatic test_random();
    logic l, r, h, b, t;
    l = 0; r = 0; h = 0; b = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: l = ~l;
          1: r = ~r;
          2: h = ~h;
          default: b = ~b;
        endcase
      end
      t = ($urandom_range(0, 2) == 0);
      step_cycle(t, l, r, h, b);
      checks++;
      if (bus.duty !== model_duty() || bus.busy !== (m_pos >= 0) ||
          bus.active_side !== m_side) begin
        errors++;
        $display("FAIL random_c%0d: duty=%h busy=%b side=%b, want %h/%b/%b", c,
                 bus.duty, bus.busy, bus.active_side, model_duty(), (m_pos >= 0), m_side);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_turn();
    test_gap_repeat();
    test_hazard_vs_turn();
    test_brake_overlay();
    test_withdrawal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
